// File: rtl/route_compute_stage_if.sv
// Valid/ready flit handshake between the input buffer, the route-compute stage
// and the switch allocator. The stage takes the slave view; the environment takes the master view.
interface route_compute_stage_if #(
   parameter int FLIT_WIDTH  = 32,
   parameter int ROUTE_WIDTH = 3
);
   logic                   in_valid;
   logic                   in_ready;
   logic [FLIT_WIDTH-1:0]  in_flit;
   logic                   out_valid;
   logic                   out_ready;
   logic [FLIT_WIDTH-1:0]  out_flit;
   logic [ROUTE_WIDTH-1:0] out_port;

   modport slave (
      input  in_valid, in_flit, out_ready,
      output in_ready, out_valid, out_flit, out_port
   );

   modport master (
      output in_valid, in_flit, out_ready,
      input  in_ready, out_valid, out_flit, out_port
   );
endinterface

// File: rtl/route_compute_stage.sv
// Route-compute stage: looks up the output port of each head flit, locks it for the packet,
// and forwards flits through an output register plus skid register. Define RC_DROP_CNT_EN for the drop counter.
module route_compute_stage #(
   parameter int NUM_ROWS       = 2,
   parameter int NUM_COLS       = 2,
   parameter int NUM_OUTPUTS    = 5,
   parameter int ROUTE_WIDTH    = $clog2(NUM_OUTPUTS),
   parameter int RTR_ADDR_WIDTH = $clog2(NUM_ROWS * NUM_COLS),
   parameter int FLIT_WIDTH     = 32
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_ROWS*NUM_COLS-1:0][ROUTE_WIDTH-1:0]  routing_table,
   route_compute_stage_if.slave                           bus,
   output logic                                           drop_pulse,
   output logic [15:0]                                    drop_count
);

   localparam int NUM_ROUTERS = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DROP
   } state_t;

   state_t                   state;
   logic [ROUTE_WIDTH-1:0]   locked_port;
   logic                     skid_valid;
   logic [FLIT_WIDTH-1:0]    skid_flit;
   logic [ROUTE_WIDTH-1:0]   skid_port;

   logic                      accept;
   logic                      is_head;
   logic                      is_tail;
   logic                      dest_ok;
   logic [RTR_ADDR_WIDTH-1:0] dest;
   logic                      enq;
   logic                      discard;
   logic [ROUTE_WIDTH-1:0]    enq_port;
   logic                      out_free;
   logic                      skid_next;

   assign accept   = bus.in_valid && bus.in_ready;
   assign is_head  = bus.in_flit[FLIT_WIDTH-1];
   assign is_tail  = bus.in_flit[FLIT_WIDTH-2];
   assign dest     = bus.in_flit[RTR_ADDR_WIDTH-1:0];
   // Widened compare: on power-of-two meshes every address is in range.
   assign dest_ok  = 32'(dest) < 32'(NUM_ROUTERS);
   assign out_free = !bus.out_valid || bus.out_ready;

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      enq       = 1'b0;
      discard   = 1'b0;
      enq_port  = locked_port;
      skid_next = skid_valid;
      if (accept) begin
         unique case (state)
            IDLE: begin
               if (is_head && dest_ok) begin
                  enq      = 1'b1;
                  enq_port = routing_table[dest];
               end else begin
                  discard = 1'b1;
               end
            end
            ROUTE:   enq     = 1'b1;
            DROP:    discard = 1'b1;
            default: discard = 1'b1;
         endcase
      end
      if (skid_valid && out_free)
         skid_next = 1'b0;
      else if (enq && !out_free)
         skid_next = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: payload registers are reset too; they are few, and out_flit must read 0 out of reset.
         state         <= IDLE;
         locked_port   <= '0;
         skid_valid    <= 1'b0;
         skid_flit     <= '0;
         skid_port     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_flit  <= '0;
         bus.out_port  <= '0;
         bus.in_ready  <= 1'b0;
         drop_pulse    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         drop_pulse   <= discard;
         bus.in_ready <= !skid_next;

         if (accept) begin
            case (state)
               IDLE: begin
                  if (is_head && !is_tail) begin
                     state       <= dest_ok ? ROUTE : DROP;
                     locked_port <= enq_port;
                  end
               end
               ROUTE, DROP: begin
                  if (is_tail)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end

         // The skid always holds the older flit, so it drains before any new input.
         if (skid_valid) begin
            if (out_free) begin
               bus.out_valid <= 1'b1;
               bus.out_flit  <= skid_flit;
               bus.out_port  <= skid_port;
               skid_valid    <= 1'b0;
            end
         end else if (enq) begin
            if (out_free) begin
               bus.out_valid <= 1'b1;
               bus.out_flit  <= bus.in_flit;
               bus.out_port  <= enq_port;
            end else begin
               skid_valid <= 1'b1;
               skid_flit  <= bus.in_flit;
               skid_port  <= enq_port;
            end
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

`ifdef RC_DROP_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         drop_count <= '0;
      else if (drop_pulse && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end
`else
   assign drop_count = '0;
`endif

endmodule
